// File: rtl/drbg_pad_buffer_if.sv
// Host seed, generator (drbg_if) and pad-word signals of drbg_pad_buffer.
// The slave modport is the buffer's view; master is the environment's view.
interface drbg_pad_buffer_if #(
  parameter int unsigned FIFO_DEPTH = 512
);
  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

  logic [383:0]  seed_i;
  logic          seed_valid_i;
  logic          seed_ready_o;
  logic          drbg_start_o;
  logic [383:0]  drbg_seed_o;
  logic          drbg_ready_i;
  logic [127:0]  drbg_out_i;
  logic          drbg_valid_i;
  logic [63:0]   pad_o;
  logic          pad_valid_o;
  logic          pad_ready_i;
  logic [LW-1:0] fill_level_o;
  logic          busy_o;
  logic          overflow_o;

  modport slave (
    input  seed_i, seed_valid_i, drbg_ready_i, drbg_out_i, drbg_valid_i, pad_ready_i,
    output seed_ready_o, drbg_start_o, drbg_seed_o, pad_o, pad_valid_o,
           fill_level_o, busy_o, overflow_o
  );

  modport master (
    output seed_i, seed_valid_i, drbg_ready_i, drbg_out_i, drbg_valid_i, pad_ready_i,
    input  seed_ready_o, drbg_start_o, drbg_seed_o, pad_o, pad_valid_o,
           fill_level_o, busy_o, overflow_o
  );
endinterface

// File: rtl/drbg_pad_buffer.sv
// Launches one DRBG burst per host seed, buffers the 128-bit blocks in a FWFT FIFO
// and serves them as 64-bit pad words (low half first) through a one-word output stage.
module drbg_pad_buffer #(
  parameter int unsigned OUTPUT_BLOCKS = 512,
  parameter int unsigned FIFO_DEPTH    = 512
) (
  input  logic               clk,
  input  logic               reset_n,
  drbg_pad_buffer_if.slave   bus
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = $clog2(OUTPUT_BLOCKS + 1);

  typedef enum logic [1:0] {IDLE, START, COLLECT, FINISH} state_t;

  state_t        state;
  logic [383:0]  seed_q;
  logic          start_q;
  logic          busy_q;
  logic          overflow_q;
  logic [CW-1:0] blk_cnt;

  logic [127:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] count;

  logic          stage_full;
  logic          stage_half;
  logic [63:0]   stage_hi;
  logic [63:0]   pad_q;

  logic          fifo_full;
  logic          wr_en;
  logic          rd_en;
  logic [LW-1:0] free_slots;
  logic          seed_ready;
  logic          seed_hs;

  assign fifo_full  = (count == LW'(FIFO_DEPTH));
  assign wr_en      = bus.drbg_valid_i && (state == COLLECT) && !fifo_full;
  assign rd_en      = (count != '0) && (!stage_full || (stage_half && bus.pad_ready_i));
  assign free_slots = LW'(FIFO_DEPTH) - count;
  // Only start a burst when every block of it is guaranteed a FIFO slot.
  assign seed_ready = (state == IDLE) && bus.drbg_ready_i && (free_slots >= LW'(OUTPUT_BLOCKS));
  assign seed_hs    = bus.seed_valid_i && seed_ready;

  // Burst control FSM; seed register is held from START until FINISH exits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      seed_q     <= '0;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
      blk_cnt    <= '0;
    end else begin
      if (bus.drbg_valid_i && !wr_en) overflow_q <= 1'b1;
      case (state)
        IDLE: begin
          if (seed_hs) begin
            seed_q  <= bus.seed_i;
            blk_cnt <= '0;
            start_q <= 1'b1;
            busy_q  <= 1'b1;
            state   <= START;
          end
        end
        START: begin
          if (!bus.drbg_ready_i) begin
            start_q <= 1'b0;
            state   <= COLLECT;
          end
        end
        COLLECT: begin
          if (wr_en) begin
            blk_cnt <= blk_cnt + CW'(1);
            if (blk_cnt == CW'(OUTPUT_BLOCKS - 1)) state <= FINISH;
          end
        end
        FINISH: begin
          if (bus.drbg_ready_i) begin
            seed_q <= '0;
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= bus.drbg_out_i;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  // Output stage: reloads in the cycle its high half is taken, so words stream without bubbles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stage_full <= 1'b0;
      stage_half <= 1'b0;
      stage_hi   <= '0;
      pad_q      <= '0;
    end else if (rd_en) begin
      stage_full <= 1'b1;
      stage_half <= 1'b0;
      stage_hi   <= mem[rd_ptr][127:64];
      pad_q      <= mem[rd_ptr][63:0];
    end else if (stage_full && bus.pad_ready_i) begin
      if (!stage_half) begin
        stage_half <= 1'b1;
        pad_q      <= stage_hi;
      end else begin
        stage_full <= 1'b0;
      end
    end
  end

  assign bus.seed_ready_o = seed_ready;
  assign bus.drbg_start_o = start_q;
  assign bus.drbg_seed_o  = seed_q;
  assign bus.pad_o        = pad_q;
  assign bus.pad_valid_o  = stage_full;
  assign bus.fill_level_o = count;
  assign bus.busy_o       = busy_q;
  assign bus.overflow_o   = overflow_q;
endmodule

// File: doc/drbg_pad_buffer.md
Name: drbg_pad_buffer

Overview:
- Initiator/consumer end of the drbg_if protocol: launches one generation burst per host seed, captures the OUTPUT_BLOCKS 128-bit blocks the generator pushes, buffers them, and serves them as 64-bit pad words to the 64-bit DMA datapath.
- The generator has no backpressure, so this block starts a burst only when the whole burst is guaranteed to fit in the buffer.

Parameters:
- OUTPUT_BLOCKS, 512, 128-bit blocks per generator burst; must equal the generator's OUTPUT_BLOCKS.
- FIFO_DEPTH, 512, buffer depth in 128-bit entries; power of two; must be >= OUTPUT_BLOCKS.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- seed_i  in  384  host seed: [383:128] key material, [127:0] V material
- seed_valid_i  in  1  seed offer
- seed_ready_o  out  1  seed accepted on cycle with seed_valid_i & seed_ready_o
- drbg_start_o  out  1  drbg_if.start
- drbg_seed_o  out  384  drbg_if.seed
- drbg_ready_i  in  1  drbg_if.ready
- drbg_out_i  in  128  drbg_if.out
- drbg_valid_i  in  1  drbg_if.valid, single-cycle pulse per block
- pad_o  out  64  pad word
- pad_valid_o  out  1  pad word valid
- pad_ready_i  in  1  downstream accepts on pad_valid_o & pad_ready_i
- fill_level_o  out  $clog2(FIFO_DEPTH)+1  entries in FIFO, excluding the output stage
- busy_o  out  1  burst in progress (state != IDLE)
- overflow_o  out  1  sticky error flag

Behaviour:
- Reset (asynchronous, active-low): state IDLE; seed register 0; block counter 0; FIFO empty; output stage empty.
- Output values in reset: seed_ready_o=0, drbg_start_o=0, drbg_seed_o=0, pad_o=0, pad_valid_o=0, fill_level_o=0, busy_o=0, overflow_o=0.
- Reset mid-burst discards all buffered data. The generator is reset by the same reset_n.
- seed_ready_o = (state==IDLE) & drbg_ready_i & (FIFO_DEPTH - fill_level_o >= OUTPUT_BLOCKS). Combinational.
- FSM IDLE: on seed handshake, register seed_i into drbg_seed_o, clear the counter, go to START.
- FSM START: drbg_start_o=1 (registered, held). When drbg_ready_i==0, drop start and go to COLLECT.
- FSM COLLECT: each drbg_valid_i writes drbg_out_i into the FIFO and increments the counter. When the counter reaches OUTPUT_BLOCKS, go to FINISH.
- FSM FINISH: wait for drbg_ready_i==1. Then zeroize drbg_seed_o and go to IDLE.
- Seed stability: drbg_seed_o stays constant from the START entry until FINISH exit, because the generator samples the seed several cycles after start.
- drbg_valid_i is sampled in every state.
  - Outside COLLECT, or when the FIFO is full: the block is dropped and overflow_o is set.
  - overflow_o clears only on reset.
  - The counter never exceeds OUTPUT_BLOCKS.
- FIFO: first-word-fall-through; pointers are $clog2(FIFO_DEPTH) bits and wrap naturally. A write and a read in the same cycle leave fill_level_o unchanged.
- Output stage holds one 128-bit word plus a half select.
  - The low half [63:0] is presented first, then the high half [127:64].
  - The stage loads from the FIFO when it is empty, or in the same cycle its high half is accepted (back-to-back words, no bubble).
- Latency: a block sampled by drbg_valid_i at edge N into an empty buffer/stage gives pad_valid_o=1 after edge N+1, with pad_o = block[63:0].
- pad_o and pad_valid_o hold stable while pad_valid_o & ~pad_ready_i. After the last half is consumed with the FIFO empty, pad_valid_o=0 and pad_o keeps its last value.
- Throughput: one pad word per cycle while data is available. The FIFO never blocks the generator because of the admission check.

Test Plan:
- Reset then idle, drbg_ready_i=1 → seed_ready_o=1; all other outputs 0.
- Seed handshake (seed_i=384'h1..., OUTPUT_BLOCKS=4, FIFO_DEPTH=8 bench model) with pad_ready_i=1 → drbg_start_o held until ready drops; drbg_seed_o stable; 8 pad words = low/high halves of blocks 0..3 in order; FINISH→IDLE after ready rises; drbg_seed_o=0.
- Same burst with pad_ready_i=0 → fill_level_o ramps 0→3 (one block in stage); seed_ready_o=0 while free space <4; releasing pad_ready_i drains 8 words, then seed_ready_o=1.
- Stray drbg_valid_i pulse in IDLE → no FIFO write; overflow_o=1 and stays 1 until reset_n low.
- Random pad_ready_i stalls across two back-to-back bursts with FIFO pointer wrap → word order and count (16 words) exact; pad_o stable during stalls.
- Assert reset_n low mid-COLLECT (asynchronous, mid-cycle) → outputs immediately return to reset values; the next seed burst behaves as in scenario 2.
